// File: rtl/alarm_zone_controller_pkg.sv
// Shared state codes and keypad status constants
// for the alarm zone controller slice.
package alarm_pkg;

  typedef enum logic [2:0] {
    ST_DISARMED = 3'd0,
    ST_EXIT     = 3'd1,
    ST_ARMED    = 3'd2,
    ST_ENTRY    = 3'd3,
    ST_ALARM    = 3'd4,
    ST_SILENT   = 3'd5
  } state_t;

  localparam logic [1:0] KEY_OK    = 2'd0;
  localparam logic [1:0] KEY_ERROR = 2'd2;
  localparam logic [1:0] NO_KEY    = 2'd3;

  // Code 1 is unused by the checker and reads as idle
  function automatic logic key_idle(
    input logic [1:0] k
  );
    return (k == NO_KEY) || (k == 2'd1);
  endfunction

endpackage

// File: rtl/alarm_zone_controller_if.sv
// Sensor/keypad inputs and status outputs
// of the alarm zone controller.
interface alarm_zone_controller_if #(
  parameter int N_ZONES = 4
);
  logic [N_ZONES-1:0] ZONE_IN;
  logic [1:0]         KEY_STATUS;
  logic               SIREN_OUT;
  logic [2:0]         STATE_OUT;
  logic               ARMED_OUT;
  logic [N_ZONES-1:0] ZONE_LATCH;
  logic [1:0]         ERR_CNT_OUT;

  modport master (
    output ZONE_IN, KEY_STATUS,
    input  SIREN_OUT, STATE_OUT, ARMED_OUT,
    input  ZONE_LATCH, ERR_CNT_OUT
  );

  modport slave (
    input  ZONE_IN, KEY_STATUS,
    output SIREN_OUT, STATE_OUT, ARMED_OUT,
    output ZONE_LATCH, ERR_CNT_OUT
  );
endinterface

// File: rtl/alarm_zone_controller_delay_counter.sv
// Loadable down-counter shared by all timed states;
// holds at zero instead of wrapping.
module delay_counter #(
  parameter int CNT_W = 18
) (
  input  logic             CLK,
  input  logic             RST_N,
  input  logic             load,
  input  logic [CNT_W-1:0] value,
  input  logic             en,
  output logic             zero
);

  logic [CNT_W-1:0] cnt;

  assign zero = (cnt == '0);

  // Load wins over decrement; stop at zero
  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      cnt <= '0;
    end else if (load) begin
      cnt <= value;
    end else if (en && !zero) begin
      cnt <= cnt - 1'b1;
    end
  end

endmodule

// File: rtl/alarm_zone_controller.sv
// Home-alarm core FSM: exit/entry delays, zone
// latch, wrong-key lockout and siren timeout.
module alarm_zone_controller
  import alarm_pkg::*;
#(
  parameter int N_ZONES = 4,
  parameter logic [N_ZONES-1:0] DELAYED_MASK = 4'b0010,
  parameter int CNT_W       = 18,
  parameter int EXIT_TICKS  = 150000,
  parameter int ENTRY_TICKS = 150000,
  parameter int SIREN_TICKS = 200000,
  parameter int MAX_KEY_ERR = 3
) (
  input logic CLK,
  input logic RST_N,
  alarm_zone_controller_if.slave bus
);

  localparam int CMAX = (1 << CNT_W) - 1;

  if (EXIT_TICKS > CMAX || ENTRY_TICKS > CMAX ||
      SIREN_TICKS > CMAX) begin : g_bad_ticks
    $error("tick parameter exceeds CNT_W");
  end

  localparam logic [1:0] MAX_E = 2'(MAX_KEY_ERR);

  logic [N_ZONES-1:0] z1, zs;
  logic [1:0]         key_r, key_prev;
  state_t             state, nxt;
  logic               siren, armed;
  logic [1:0]         err_cnt;
  logic [N_ZONES-1:0] latch;
  logic               load, zero;
  logic [CNT_W-1:0]   load_val;
  logic               ev, ok_ev, err_ev;
  logic               in_armed, lockout;
  logic               inst, dly, fresh;

  // Zone synchroniser and registered key status
  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      z1       <= '0;
      zs       <= '0;
      key_r    <= NO_KEY;
      key_prev <= NO_KEY;
    end else begin
      z1       <= bus.ZONE_IN;
      zs       <= z1;
      key_r    <= bus.KEY_STATUS;
      key_prev <= key_r;
    end
  end

  assign ev     = key_idle(key_prev) && !key_idle(key_r);
  assign ok_ev  = ev && (key_r == KEY_OK);
  assign err_ev = ev && (key_r == KEY_ERROR);

  assign in_armed = (state == ST_EXIT) ||
                    (state == ST_ARMED) ||
                    (state == ST_ENTRY);
  assign lockout  = in_armed && (err_cnt >= MAX_E);
  assign inst     = |(zs & ~DELAYED_MASK);
  assign dly      = |(zs & DELAYED_MASK);
  assign fresh    = |(zs & ~latch);

  // Next state with OK > lockout > zone > expiry
  always_comb begin
    nxt = state;
    unique case (state)
      ST_DISARMED: if (ok_ev) nxt = ST_EXIT;
      ST_EXIT: begin
        if (ok_ev)        nxt = ST_DISARMED;
        else if (lockout) nxt = ST_ALARM;
        else if (zero)    nxt = ST_ARMED;
      end
      ST_ARMED: begin
        if (ok_ev)        nxt = ST_DISARMED;
        else if (lockout) nxt = ST_ALARM;
        else if (inst)    nxt = ST_ALARM;
        else if (dly)     nxt = ST_ENTRY;
      end
      ST_ENTRY: begin
        if (ok_ev)        nxt = ST_DISARMED;
        else if (lockout) nxt = ST_ALARM;
        else if (inst)    nxt = ST_ALARM;
        else if (zero)    nxt = ST_ALARM;
      end
      ST_ALARM: begin
        if (ok_ev)        nxt = ST_DISARMED;
        else if (zero)    nxt = ST_SILENT;
      end
      ST_SILENT: begin
        if (ok_ev)        nxt = ST_DISARMED;
        else if (fresh)   nxt = ST_ALARM;
      end
      default: nxt = ST_DISARMED;
    endcase
  end

  // Counter reload whenever a timed state is entered
  always_comb begin
    load     = (nxt != state);
    load_val = '0;
    unique case (1'b1)
      (nxt == ST_EXIT):  load_val = CNT_W'(EXIT_TICKS);
      (nxt == ST_ENTRY): load_val = CNT_W'(ENTRY_TICKS);
      (nxt == ST_ALARM): load_val = CNT_W'(SIREN_TICKS);
      default:           load_val = '0;
    endcase
  end

  delay_counter #(
    .CNT_W (CNT_W)
  ) u_cnt (
    .CLK   (CLK),
    .RST_N (RST_N),
    .load  (load),
    .value (load_val),
    .en    (1'b1),
    .zero  (zero)
  );

  // State, registered outputs, error count, zone record
  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      state   <= ST_DISARMED;
      siren   <= 1'b0;
      armed   <= 1'b0;
      err_cnt <= '0;
      latch   <= '0;
    end else begin
      state <= nxt;
      siren <= (nxt == ST_ALARM);
      armed <= (nxt != ST_DISARMED);
      if (ok_ev) begin
        err_cnt <= '0;
      end else if (err_ev && in_armed &&
                   err_cnt != 2'd3) begin
        err_cnt <= err_cnt + 2'd1;
      end
      if (state == ST_DISARMED && ok_ev) begin
        latch <= '0;
      end else if (state != ST_DISARMED &&
                   state != ST_EXIT) begin
        latch <= latch | zs;
      end
    end
  end

  assign bus.SIREN_OUT   = siren;
  assign bus.STATE_OUT   = state;
  assign bus.ARMED_OUT   = armed;
  assign bus.ZONE_LATCH  = latch;
  assign bus.ERR_CNT_OUT = err_cnt;

endmodule

// File: tb/tb_alarm_zone_controller.sv
// Directed self-checking bench for the alarm
// zone controller with shortened timings.
module tb_alarm_zone_controller;

  localparam logic [1:0] K_OK  = 2'd0;
  localparam logic [1:0] K_ERR = 2'd2;
  localparam logic [1:0] K_NO  = 2'd3;

  logic CLK;
  logic RST_N;
  int   checks;
  int   errors;

  alarm_zone_controller_if #(.N_ZONES(4)) bus ();

  alarm_zone_controller #(
    .N_ZONES      (4),
    .DELAYED_MASK (4'b0010),
    .CNT_W        (18),
    .EXIT_TICKS   (10),
    .ENTRY_TICKS  (10),
    .SIREN_TICKS  (8),
    .MAX_KEY_ERR  (3)
  ) dut (
    .CLK   (CLK),
    .RST_N (RST_N),
    .bus   (bus)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  task automatic tick(input int n);
    for (int i = 0; i < n; i++) begin
      @(posedge CLK);
      #1;
    end
  endtask

  task automatic chk(input string tag,
                     input logic [7:0] obs,
                     input logic [7:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h",
             tag, obs, exp);
    end
  endtask

  task automatic press(input logic [1:0] k);
    bus.KEY_STATUS = k;
    tick(1);
    bus.KEY_STATUS = K_NO;
    tick(1);
  endtask

  task automatic wait_state(input logic [2:0] s,
                            input int budget,
                            input string tag);
    int n;
    n = 0;
    while (bus.STATE_OUT !== s && n < budget) begin
      tick(1);
      n++;
    end
    chk(tag, {5'd0, bus.STATE_OUT}, {5'd0, s});
  endtask

  task automatic arm();
    press(K_OK);
    chk("arm_exit", {5'd0, bus.STATE_OUT}, 8'd1);
    tick(9);
    chk("exit_hold", {5'd0, bus.STATE_OUT}, 8'd1);
    wait_state(3'd2, 4, "arm_armed");
  endtask

  initial begin
    checks = 0;
    errors = 0;
    RST_N = 1'b0;
    bus.ZONE_IN = 4'b0000;
    bus.KEY_STATUS = K_NO;
    tick(3);
    chk("rst_state", {5'd0, bus.STATE_OUT}, 8'd0);
    chk("rst_siren", {7'd0, bus.SIREN_OUT}, 8'd0);
    chk("rst_armed", {7'd0, bus.ARMED_OUT}, 8'd0);
    chk("rst_latch", {4'd0, bus.ZONE_LATCH}, 8'd0);
    chk("rst_err", {6'd0, bus.ERR_CNT_OUT}, 8'd0);
    RST_N = 1'b1;
    tick(2);

    // ERROR while disarmed is ignored
    press(K_ERR);
    tick(1);
    chk("dis_err", {6'd0, bus.ERR_CNT_OUT}, 8'd0);
    chk("dis_state", {5'd0, bus.STATE_OUT}, 8'd0);

    // Arm, instant zone0 -> ALARM
    arm();
    chk("armed_out", {7'd0, bus.ARMED_OUT}, 8'd1);
    bus.ZONE_IN = 4'b0001;
    tick(2);
    chk("z0_sync", {5'd0, bus.STATE_OUT}, 8'd2);
    wait_state(3'd4, 2, "z0_alarm");
    chk("z0_siren", {7'd0, bus.SIREN_OUT}, 8'd1);
    chk("z0_latch", {4'd0, bus.ZONE_LATCH}, 8'h1);

    // Siren timeout -> SILENT, new zone2 -> ALARM
    tick(6);
    chk("siren_hold", {7'd0, bus.SIREN_OUT}, 8'd1);
    wait_state(3'd5, 6, "silent");
    chk("silent_siren", {7'd0, bus.SIREN_OUT}, 8'd0);
    chk("silent_armed", {7'd0, bus.ARMED_OUT}, 8'd1);
    tick(3);
    chk("silent_stay", {5'd0, bus.STATE_OUT}, 8'd5);
    bus.ZONE_IN = 4'b0101;
    wait_state(3'd4, 5, "z2_alarm");
    chk("z2_siren", {7'd0, bus.SIREN_OUT}, 8'd1);
    chk("z2_latch", {4'd0, bus.ZONE_LATCH}, 8'h5);
    press(K_OK);
    chk("ok_dis", {5'd0, bus.STATE_OUT}, 8'd0);
    chk("ok_siren", {7'd0, bus.SIREN_OUT}, 8'd0);
    chk("ok_armed", {7'd0, bus.ARMED_OUT}, 8'd0);
    bus.ZONE_IN = 4'b0000;
    tick(3);

    // Delayed zone1 -> ENTRY, disarm mid-delay
    arm();
    chk("rearm_latch", {4'd0, bus.ZONE_LATCH}, 8'h0);
    bus.ZONE_IN = 4'b0010;
    wait_state(3'd3, 5, "entry");
    chk("entry_siren", {7'd0, bus.SIREN_OUT}, 8'd0);
    tick(4);
    chk("entry_hold", {5'd0, bus.STATE_OUT}, 8'd3);
    press(K_OK);
    chk("entry_dis", {5'd0, bus.STATE_OUT}, 8'd0);
    chk("entry_nosir", {7'd0, bus.SIREN_OUT}, 8'd0);
    bus.ZONE_IN = 4'b0000;
    tick(3);

    // Wrong-key lockout; held ERROR counts once
    arm();
    chk("err0", {6'd0, bus.ERR_CNT_OUT}, 8'd0);
    press(K_ERR);
    chk("err1", {6'd0, bus.ERR_CNT_OUT}, 8'd1);
    bus.KEY_STATUS = K_ERR;
    tick(20);
    bus.KEY_STATUS = K_NO;
    tick(2);
    chk("err_held", {6'd0, bus.ERR_CNT_OUT}, 8'd2);
    chk("err_armed", {5'd0, bus.STATE_OUT}, 8'd2);
    press(K_ERR);
    chk("err3", {6'd0, bus.ERR_CNT_OUT}, 8'd3);
    wait_state(3'd4, 2, "lock_alarm");
    chk("lock_siren", {7'd0, bus.SIREN_OUT}, 8'd1);
    press(K_OK);
    chk("lock_dis", {5'd0, bus.STATE_OUT}, 8'd0);
    chk("lock_clr", {6'd0, bus.ERR_CNT_OUT}, 8'd0);

    // Instant and delayed zone same cycle
    arm();
    bus.ZONE_IN = 4'b0011;
    tick(2);
    chk("both_sync", {5'd0, bus.STATE_OUT}, 8'd2);
    tick(1);
    chk("both_alarm", {5'd0, bus.STATE_OUT}, 8'd4);
    chk("both_latch", {4'd0, bus.ZONE_LATCH}, 8'h3);
    press(K_OK);
    bus.ZONE_IN = 4'b0000;
    tick(3);

    // Asynchronous reset in the middle of ENTRY
    arm();
    bus.ZONE_IN = 4'b0010;
    wait_state(3'd3, 5, "rst_entry");
    chk("rst_pre", {4'd0, bus.ZONE_LATCH}, 8'h2);
    tick(1);
    #2;
    RST_N = 1'b0;
    #1;
    chk("arst_state", {5'd0, bus.STATE_OUT}, 8'd0);
    chk("arst_siren", {7'd0, bus.SIREN_OUT}, 8'd0);
    chk("arst_latch", {4'd0, bus.ZONE_LATCH}, 8'h0);
    chk("arst_armed", {7'd0, bus.ARMED_OUT}, 8'd0);
    tick(1);
    RST_N = 1'b1;
    tick(4);
    chk("post_rst", {5'd0, bus.STATE_OUT}, 8'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
